// File: rtl/board_seeder.sv
// Seeds a COLS x ROWS cellular board: draws BITS random bits per cell and writes the
// cell alive when the unsigned sample is below the density latched at run start.
module board_seeder #(
  parameter int COLS   = 32,
  parameter int ROWS   = 32,
  parameter int ADDR_W = 10,
  parameter int BITS   = 3
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              abort,
  input  logic [BITS:0]     density,
  input  logic              random_data,
  output logic              random_en,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
  output logic              done
);
  localparam int CELLS = COLS * ROWS;
  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(BITS - 1);

  typedef enum logic [1:0] {IDLE, GATHER, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0]   sample_q, sample_d;
  logic [BITS:0]     density_q, density_d;
  logic [BITS:0]     shifted;
  logic              alive;

  // First bit drawn ends up in the MSB after BITS shifts.
  assign shifted = {sample_q, random_data};
  assign alive   = ({1'b0, sample_q} < density_q);
  assign wr_addr = addr_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      bit_cnt_q <= '0;
      sample_q  <= '0;
      density_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      bit_cnt_q <= bit_cnt_d;
      sample_q  <= sample_d;
      density_q <= density_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bit_cnt_d = bit_cnt_q;
    sample_d  = sample_q;
    density_d = density_q;
    random_en = 1'b0;
    wr_en     = 1'b0;
    wr_data   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d   = GATHER;
          density_d = density;
          addr_d    = '0;
          bit_cnt_d = '0;
        end
      end
      GATHER: begin
        random_en = 1'b1;
        busy      = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          sample_d = shifted[BITS-1:0];
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = WRITE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_data = alive;
        busy    = 1'b1;
        // An abort coinciding with wr_ready still lets this write complete.
        if (wr_ready) begin
          if (abort) begin
            state_d = IDLE;
          end else if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = GATHER;
          end
        end else if (abort) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_board_seeder.sv
// Bench for board_seeder on a 4x2 board: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_board_seeder;
  localparam int COLS = 4, ROWS = 2, CELLS = 8, ADDR_W = 3, BITS = 3;

  logic clk = 1'b0, rst_b = 1'b1;
  logic start = 1'b0, abort = 1'b0, random_data = 1'b0, wr_ready = 1'b0;
  logic [BITS:0] density = '0;
  logic random_en, wr_en, wr_data, busy, done;
  logic [ADDR_W-1:0] wr_addr;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  board_seeder #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BITS(BITS)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .density(density),
    .random_data(random_data), .random_en(random_en), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is a cell index, bits gathered so far for that cell, and the value they form.
  bit m_run = 0, m_done = 0;
  int m_cell = 0, m_nbits = 0, m_sample = 0, m_dens = 0;

  initial forever begin
    @(posedge clk or negedge rst_b);
    if (!rst_b) begin
      m_run = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (start && !abort) begin
        m_run = 1; m_dens = int'(density); m_cell = 0; m_nbits = 0; m_sample = 0;
      end
    end else if (m_nbits < BITS) begin
      if (abort) m_run = 0;
      else begin
        m_sample = m_sample * 2 + int'(random_data);
        m_nbits++;
      end
    end else if (wr_ready) begin
      if (abort) m_run = 0;
      else if (m_cell == CELLS - 1) begin m_run = 0; m_done = 1; end
      else begin m_cell++; m_nbits = 0; m_sample = 0; end
    end else if (abort) begin
      m_run = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    check("busy", int'(busy), int'(m_run));
    check("done", int'(done), int'(m_done));
    check("random_en", int'(random_en), int'(m_run && m_nbits < BITS));
    check("wr_en", int'(wr_en), int'(m_run && m_nbits == BITS));
    if (m_run && m_nbits == BITS) begin
      check("wr_addr", int'(wr_addr), m_cell);
      check("wr_data", int'(wr_data), int'(m_sample < m_dens));
    end
  end

  int wq_addr[$], wq_data[$], en_q[$];
  int en_cnt = 0, done_cnt = 0;
  bit tb_bits [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_log();
    wq_addr.delete(); wq_data.delete(); en_q.delete();
    en_cnt = 0; done_cnt = 0;
  endtask

  // Observe the current cycle at the falling edge, then drive inputs for the next rising edge.
  task automatic step(input bit s, input bit a, input bit rdy, input bit rd, input bit mid);
    @(negedge clk);
    if (random_en) en_cnt++;
    if (done) done_cnt++;
    if (wr_en && rdy) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(int'(wr_data));
      en_q.push_back(en_cnt);
      en_cnt = 0;
    end
    start = mid ? (s && busy) : s;
    abort = a; wr_ready = rdy; random_data = rd;
  endtask

  task automatic run_to_idle(input int budget, input int rdy_pct, input int abort_pm, input int start_pct);
    bit ended = 0;
    for (int n = 0; n < budget && !ended; n++) begin
      step($urandom_range(99) < start_pct, $urandom_range(999) < abort_pm,
           $urandom_range(99) < rdy_pct, 1'($urandom), 1'b1);
      if (!busy && !done) ended = 1;
    end
    check("run_bounded", int'(ended), 1);
  endtask

  task automatic check_full_seq(input string name, input int dval);
    check({name, "_writes"}, wq_addr.size(), CELLS);
    for (int i = 0; i < CELLS; i++) begin
      check({name, "_addr"}, qget(wq_addr, i), i);
      if (dval >= 0) check({name, "_data"}, qget(wq_data, i), dval);
    end
    check({name, "_done"}, done_cnt, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc, a0, d0;
    #1 rst_b = 1'b0;
    repeat (3) step(0, 0, 0, 0, 0);
    check("rst_random_en", int'(random_en), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    @(negedge clk); rst_b = 1'b1;
    repeat (3) step(0, 0, 1, 0, 0);
    check("post_rst_idle", int'(busy), 0);

    // start together with abort must not launch a run
    step(1, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("start_abort_idle", int'(busy), 0);

    // full-alive run: done lands on cycle 33 counted from the first gather cycle
    clear_log(); density = 4'd8; dc = 0;
    step(1, 0, 1, 1'($urandom), 0);
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 1, 1'($urandom), 0);
      if (done && dc == 0) dc = k;
    end
    check("full_done_cycle", dc, 33);
    check_full_seq("full", 1);
    for (int i = 0; i < CELLS; i++) check("full_en_per_cell", qget(en_q, i), BITS);

    // threshold decode: samples 3 and 4 against density 4
    clear_log(); density = 4'd4;
    step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 8; k++) step(0, 0, 1, tb_bits[k-1], 0);
    step(0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    check("thr_writes", wq_data.size(), 2);
    check("thr_cell0", qget(wq_data, 0), 1);
    check("thr_cell1", qget(wq_data, 1), 0);
    check("thr_en0", qget(en_q, 0), 3);
    check("thr_en1", qget(en_q, 1), 3);

    // backpressure on the first write
    clear_log(); density = 4'($urandom_range(15));
    step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) step(0, 0, 1, 1'($urandom), 0);
    step(0, 0, 0, 0, 0);
    check("bp_wr_en", int'(wr_en), 1);
    a0 = int'(wr_addr); d0 = int'(wr_data);
    check("bp_addr0", a0, 0);
    for (int k = 5; k <= 8; k++) begin
      step(0, 0, 0, 1'($urandom), 0);
      check("bp_hold_en", int'(wr_en), 1);
      check("bp_hold_addr", int'(wr_addr), a0);
      check("bp_hold_data", int'(wr_data), d0);
      check("bp_rnd_en", int'(random_en), 0);
    end
    run_to_idle(100, 100, 0, 0);
    check_full_seq("bp", -1);

    // abort during the gather phase of cell 3
    clear_log(); density = 4'd15;
    step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 12; k++) step(0, 0, 1, 1'($urandom), 0);
    step(0, 1, 1, 1'($urandom), 0);
    check("ab_in_gather", int'(random_en), 1);
    step(0, 0, 1, 0, 0);
    check("ab_busy", int'(busy), 0);
    check("ab_wr_en", int'(wr_en), 0);
    check("ab_rnd_en", int'(random_en), 0);
    repeat (4) step(0, 0, 1, 0, 0);
    check("ab_writes", wq_addr.size(), 3);
    check("ab_last_addr", qget(wq_addr, 2), 2);
    check("ab_no_done", done_cnt, 0);
    clear_log();
    step(1, 0, 1, 0, 0);
    run_to_idle(100, 100, 0, 0);
    check_full_seq("restart", 1);

    // start pulses while busy must not disturb the address walk
    clear_log(); density = 4'($urandom_range(15));
    step(1, 0, 1, 0, 0);
    run_to_idle(300, 70, 0, 40);
    check_full_seq("sbusy", -1);

    // asynchronous reset in the middle of a write
    clear_log(); density = 4'd9;
    step(1, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) step(0, 0, 1, 1'($urandom), 0);
    step(0, 0, 0, 0, 0);
    check("ar_pre_wr_en", int'(wr_en), 1);
    #2 rst_b = 1'b0;
    #1;
    check("ar_random_en", int'(random_en), 0);
    check("ar_wr_en", int'(wr_en), 0);
    check("ar_wr_addr", int'(wr_addr), 0);
    check("ar_wr_data", int'(wr_data), 0);
    check("ar_busy", int'(busy), 0);
    check("ar_done", int'(done), 0);
    repeat (2) step(0, 0, 1, 0, 0);
    @(negedge clk); rst_b = 1'b1;
    repeat (10) step(0, 0, 1, 1'($urandom), 0);
    check("ar_no_done", done_cnt, 0);
    check("ar_no_restart", int'(busy), 0);

    // randomized runs with random density, backpressure, aborts and stray starts
    for (int r = 0; r < 14; r++) begin
      clear_log();
      density = (r == 0) ? 4'd0 : (r == 1) ? 4'd12 : 4'($urandom_range(15));
      step(1, 0, 1, 1'($urandom), 0);
      run_to_idle(400, 60, (r < 2) ? 0 : 15, 5);
      if (r == 0) check_full_seq("dens0", 0);
      if (r == 1) check_full_seq("dens12", 1);
      repeat (2) step(0, 0, 1, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
